uart_transmitter: RTL

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter_pkg.sv | 25 ++
 rtl/uart_transmitter_if.sv | 17 +
 rtl/uart_transmitter_sync_fifo.sv | 65 ++++++
 rtl/uart_transmitter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/uart_transmitter_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, frame size,
// parity mode constants and the parity helper.
package uart_transmitter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_GAP    = 3'd5
  } tx_state_e;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  // XOR of the data byte, inverted in odd mode
  function automatic logic parity_bit(input logic [7:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte-load side and serial-line side of the UART transmitter.
// Handshake: a byte on data is taken on any posedge where load=1 and
// ready=1; load=1 with ready=0 is dropped and flagged on overflow. The
// loader may change data freely once the accepting edge has passed.
interface uart_transmitter_if;
  logic [7:0] data;
  logic       load;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       overflow;

  modport master (output data, output load,
                  input ready, input tx, input busy, input overflow);
  modport slave  (input data, input load,
                  output ready, output tx, output busy, output overflow);
endinterface

// File: rtl/uart_transmitter_sync_fifo.sv
// Circular byte buffer with wrap-around pointers and an occupancy count.
// Writes to a full buffer and reads from an empty one are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointer advance and count update; a simultaneous write and read cancel out
  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: buffered bytes are sent as start, 8 data bits LSB
// first, parity and stop, each bit BIT_CYCLES clocks wide, followed by
// GAP_BITS idle-high bit periods before the next frame.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int BIT_CYCLES = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_BITS   = 2,
  parameter int PARITY_ODD = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_transmitter_if.slave   bus,
  output tx_state_e           dbg_state
);
  localparam logic [7:0] BAUD_LAST = 8'(BIT_CYCLES - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_BITS - 1);
  localparam logic       ODD_SEL   = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  tx_state_e  state_q, state_d;
  logic [7:0] baud_q, baud_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [3:0] gap_q, gap_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic       tx_q, tx_d;
  logic       overflow_q, overflow_d;

  logic                          bit_done;
  logic                          ready;
  logic                          fifo_pop;
  logic [7:0]                    fifo_rd_data;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  assign ready        = !fifo_full;
  assign bus.ready    = ready;
  assign bus.tx       = tx_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = !((state_q == ST_IDLE) && (fifo_count == '0));
  assign dbg_state    = state_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bus.load && ready),
    .wr_data (bus.data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Framing FSM with baud counter, bit index, gap counter and shift register
  always_comb begin
    bit_done  = (baud_q == BAUD_LAST);
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    gap_d     = gap_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    fifo_pop  = 1'b0;
    if (state_q != ST_IDLE) baud_d = bit_done ? 8'd0 : baud_q + 8'd1;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_rd_data;
          parity_d  = parity_bit(fifo_rd_data, ODD_SEL);
          bit_idx_d = 3'd0;
          baud_d    = 8'd0;
          state_d   = ST_START;
        end
      end
      ST_START:  if (bit_done) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = ST_PARITY;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      ST_PARITY: if (bit_done) state_d = ST_STOP;
      ST_STOP: begin
        if (bit_done) begin
          state_d = ST_GAP;
          gap_d   = 4'd0;
        end
      end
      ST_GAP: begin
        if (bit_done) begin
          if (gap_q == GAP_LAST) state_d = ST_IDLE;
          else gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level follows the state one cycle later; sticky overflow on dropped loads
  always_comb begin
    tx_d       = 1'b1;
    overflow_d = overflow_q | (bus.load & ~ready);
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
      ST_PARITY: tx_d = parity_q;
      default:   tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame and idles the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      gap_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      gap_q      <= gap_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
